// File: rtl/mem_arb_pkg.sv
// Shared definitions for the Mem256X16 two-port access arbiter.
// Holds the RAM geometry, the sequencer state encoding and the requester ids
// used by both the top level and the two-way picker.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/arb2_pick.sv
// Combinational two-way picker for the Mem256X16 arbiter.
// With MEM_ARB_RR_EN defined, contention goes to the port that did not win
// last; otherwise port A always beats port B and last_id is ignored.
module arb2_pick
    import mem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_id,
    output logic win_id,
    output logic any_req
);

    assign any_req = req_a | req_b;

`ifdef MEM_ARB_RR_EN
    // Round-robin: on contention hand the grant to whoever did not win last.
    always_comb begin
        win_id = ID_A;
        if (req_a && req_b) begin
            win_id = ~last_id;
        end else if (req_b) begin
            win_id = ID_B;
        end
    end
`else
    logic unusedLastId;
    assign unusedLastId = last_id;

    // Fixed priority: B only wins when A is not asking.
    always_comb begin
        win_id = ID_A;
        if (!req_a && req_b) begin
            win_id = ID_B;
        end
    end
`endif

endmodule

// File: rtl/mem256x16_arbiter.sv
// Two-port access arbiter and sequencer for the Mem256X16 single-port RAM.
// Each access takes IDLE -> ACCESS -> RESP; the winner is latched in IDLE,
// the RAM is written or read in ACCESS and the ack pulses in RESP.
// Optional macro MEM_ARB_RR_EN selects round-robin instead of A-first priority.
module mem256x16_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_qout
);

    arb_state_e        state_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memData_q;
    logic              memWe_q;
    logic              aAck_q;
    logic              bAck_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic              winnerId_q;

    logic              lastId;
    logic              winId;
    logic              anyReq;

    arb2_pick u_pick (
        .req_a   (a_req),
        .req_b   (b_req),
        .last_id (lastId),
        .win_id  (winId),
        .any_req (anyReq)
    );

`ifdef MEM_ARB_RR_EN
    logic lastId_q;

    // Remember who took the most recent grant so contention alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastId_q <= ID_A;
        end else if (state_q == IDLE && anyReq) begin
            lastId_q <= winId;
        end
    end

    assign lastId = lastId_q;
`else
    assign lastId = ID_A;
`endif

    // Sequencer: latch the winner in IDLE, drive the RAM in ACCESS, ack in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            memAddr_q  <= '0;
            memData_q  <= '0;
            memWe_q    <= 1'b0;
            aAck_q     <= 1'b0;
            bAck_q     <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            winnerId_q <= ID_A;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        winnerId_q <= winId;
                        memAddr_q  <= (winId == ID_B) ? b_addr  : a_addr;
                        memData_q  <= (winId == ID_B) ? b_wdata : a_wdata;
                        memWe_q    <= (winId == ID_B) ? b_we    : a_we;
                        busy_q     <= 1'b1;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!memWe_q) begin
                        rdata_q <= mem_qout;
                    end
                    memWe_q <= 1'b0;
                    aAck_q  <= (winnerId_q == ID_A);
                    bAck_q  <= (winnerId_q == ID_B);
                    state_q <= RESP;
                end
                RESP: begin
                    aAck_q  <= 1'b0;
                    bAck_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    memWe_q <= 1'b0;
                    aAck_q  <= 1'b0;
                    bAck_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_ack    = aAck_q;
    assign b_ack    = bAck_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign mem_addr = memAddr_q;
    assign mem_data = memData_q;
    assign mem_we   = memWe_q;

endmodule

// File: tb/tb_mem256x16_arbiter.sv
// Testbench for mem256x16_arbiter: directed scenarios with literal expectations
// followed by randomized two-port traffic, all checked every cycle against a
// transaction-level model. Honours MEM_ARB_RR_EN for the arbitration rule.
module tb_mem256x16_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack, busy, mem_we;
    logic [15:0] rdata, mem_data, mem_qout;
    logic [7:0]  mem_addr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem256x16_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .rdata    (rdata),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_qout (mem_qout)
    );

    // The RAM the arbiter fronts: combinational read, write on the clock edge.
    logic [15:0] ram [256] = '{default: 16'h0000};
    assign mem_qout = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_data;
    end

    // Transaction-level model: one grant every three cycles, ack two cycles
    // after the grant, memory content tracked as a plain array.
    logic [15:0] modelMem [256] = '{default: 16'h0000};
    int          slot = 0;
    bit          lastWasB = 1'b0;
    bit          txnB, txnWe;
    logic [7:0]  txnAddr;
    logic [15:0] txnData;
    logic        expAckA, expAckB, expBusy, expMemWe;
    logic [15:0] expRdata, expData;
    logic [7:0]  expAddr;

    task automatic modelStep();
        if (rst) begin
            if (slot == 2 && txnWe) modelMem[txnAddr] = txnData;
            slot = 0; lastWasB = 1'b0;
            expAckA = 0; expAckB = 0; expBusy = 0; expMemWe = 0;
            expRdata = 16'h0; expAddr = 8'h0; expData = 16'h0;
        end else if (slot == 0) begin
            expAckA = 0; expAckB = 0;
            if (a_req || b_req) begin
`ifdef MEM_ARB_RR_EN
                txnB = (a_req && b_req) ? !lastWasB : b_req;
                lastWasB = txnB;
`else
                txnB = !a_req;
`endif
                txnWe   = txnB ? b_we    : a_we;
                txnAddr = txnB ? b_addr  : a_addr;
                txnData = txnB ? b_wdata : a_wdata;
                expAddr = txnAddr; expData = txnData;
                expMemWe = txnWe; expBusy = 1; slot = 2;
            end else begin
                expMemWe = 0; expBusy = 0;
            end
        end else if (slot == 2) begin
            if (txnWe) modelMem[txnAddr] = txnData;
            else expRdata = modelMem[txnAddr];
            expMemWe = 0; expAckA = !txnB; expAckB = txnB; slot = 1;
        end else begin
            expAckA = 0; expAckB = 0; expBusy = 0; slot = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every output against the model on every cycle.
    always @(negedge clk) begin
        checkOutput("a_ack", a_ack, expAckA);
        checkOutput("b_ack", b_ack, expAckB);
        checkOutput("busy", busy, expBusy);
        checkOutput("mem_we", mem_we, expMemWe);
        checkOutput("rdata", rdata, expRdata);
        checkOutput("mem_addr", mem_addr, expAddr);
        checkOutput("mem_data", mem_data, expData);
    end

    task automatic setPort(input bit portB, input bit req, input bit we,
                           input logic [7:0] addr, input logic [15:0] data);
        if (portB) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = data;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = data;
        end
    endtask

    // Wait (bounded) for the given port's ack; lat stays 0 on timeout.
    task automatic waitAck(input bit portB, input int limit, output int lat,
                           output int weCnt, output logic [15:0] rd);
        lat = 0; weCnt = 0; rd = 16'h0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1) weCnt++;
            if ((portB ? b_ack : a_ack) === 1'b1) begin
                lat = i; rd = rdata;
                break;
            end
        end
        #1;
    endtask

    function automatic logic [7:0] randAddr();
        case ($urandom_range(0, 5))
            0: randAddr = 8'h00;
            1: randAddr = 8'hFF;
            default: randAddr = 8'h20 + 8'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic newReq(input bit portB);
        setPort(portB, 1'b1, 1'($urandom_range(0, 1)), randAddr(), 16'($urandom));
    endtask

    // Random requester behaviour: hold until ack, then drop or reissue.
    task automatic applyStimulus();
        rst = ($urandom_range(0, 249) == 0);
        if (a_req && a_ack) begin
            if ($urandom_range(0, 1) == 1) newReq(1'b0); else a_req = 1'b0;
        end else if (!a_req && $urandom_range(0, 2) == 0) begin
            newReq(1'b0);
        end
        if (b_req && b_ack) begin
            if ($urandom_range(0, 1) == 1) newReq(1'b1); else b_req = 1'b0;
        end else if (!b_req && $urandom_range(0, 2) == 0) begin
            newReq(1'b1);
        end
    endtask

    int          lat, weCnt, acks;
    logic [15:0] rd;
    bit          firstB, expFirstB;
    bit          seq [6];

    initial begin
        rst = 1'b1;
        setPort(1'b0, 0, 0, 8'h00, 16'h0);
        setPort(1'b1, 0, 0, 8'h00, 16'h0);
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rdata", rdata, 16'h0000);
        checkOutput("reset mem_addr", mem_addr, 8'h00);
        #1 rst = 1'b0;

        $display("[TB] A write then back-to-back read");
        setPort(1'b0, 1, 1, 8'h01, 16'h0001);
        waitAck(1'b0, 10, lat, weCnt, rd);
        checkOutput("A write latency", lat, 2);
        checkOutput("A write we cycles", weCnt, 1);
        setPort(1'b0, 1, 0, 8'h01, 16'h0000);
        waitAck(1'b0, 10, lat, weCnt, rd);
        checkOutput("A read latency", lat, 3);
        checkOutput("A read data", rd, 16'h0001);
        checkOutput("A read we cycles", weCnt, 0);
        a_req = 1'b0;

        $display("[TB] simultaneous writes from A and B");
        @(negedge clk); #1;
        setPort(1'b0, 1, 1, 8'h84, 16'h0006);
        setPort(1'b1, 1, 1, 8'h48, 16'h0012);
        lat = 0; firstB = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (a_ack === 1'b1 || b_ack === 1'b1) begin
                lat = i; firstB = (b_ack === 1'b1);
                break;
            end
        end
        #1;
`ifdef MEM_ARB_RR_EN
        expFirstB = 1'b1;
`else
        expFirstB = 1'b0;
`endif
        checkOutput("contention latency", lat, 2);
        checkOutput("contention winner", firstB, expFirstB);
        if (firstB) b_req = 1'b0; else a_req = 1'b0;
        waitAck(!firstB, 10, lat, weCnt, rd);
        checkOutput("loser ack gap", lat, 3);
        if (firstB) a_req = 1'b0; else b_req = 1'b0;
        setPort(1'b0, 1, 0, 8'h84, 16'h0);
        waitAck(1'b0, 10, lat, weCnt, rd);
        checkOutput("readback 0x84", rd, 16'h0006);
        a_req = 1'b0;
        setPort(1'b1, 1, 0, 8'h48, 16'h0);
        waitAck(1'b1, 10, lat, weCnt, rd);
        checkOutput("readback 0x48", rd, 16'h0012);
        b_req = 1'b0;

        $display("[TB] idle hold");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle busy", busy, 0);
            checkOutput("idle mem_we", mem_we, 0);
            checkOutput("idle rdata", rdata, 16'h0012);
        end
        #1;

        $display("[TB] both ports held continuously");
        setPort(1'b0, 1, 0, 8'h01, 16'h0);
        setPort(1'b1, 1, 0, 8'h02, 16'h0);
        acks = 0;
        for (int cyc = 0; cyc < 60 && acks < 6; cyc++) begin
            @(negedge clk);
            if (a_ack === 1'b1) begin seq[acks] = 1'b0; acks++; end
            else if (b_ack === 1'b1) begin seq[acks] = 1'b1; acks++; end
            #1;
            if (acks == 6) begin
                if (seq[5]) b_req = 1'b0; else a_req = 1'b0;
            end
        end
        checkOutput("held ack count", acks, 6);
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
            checkOutput($sformatf("held ack order %0d", k), seq[k], 1'(k % 2));
`else
            checkOutput($sformatf("held ack order %0d", k), seq[k], 1'b0);
`endif
        end
        if (a_req) begin
            waitAck(1'b0, 10, lat, weCnt, rd);
            checkOutput("held tail A", lat, 3);
            a_req = 1'b0;
        end
        if (b_req) begin
            waitAck(1'b1, 10, lat, weCnt, rd);
            checkOutput("held tail B", lat, 3);
            b_req = 1'b0;
        end

        $display("[TB] B write then back-to-back read");
        @(negedge clk); #1;
        setPort(1'b1, 1, 1, 8'h02, 16'h0010);
        waitAck(1'b1, 10, lat, weCnt, rd);
        checkOutput("B write latency", lat, 2);
        setPort(1'b1, 1, 0, 8'h02, 16'h0);
        waitAck(1'b1, 10, lat, weCnt, rd);
        checkOutput("B read latency", lat, 3);
        checkOutput("B read data", rd, 16'h0010);
        b_req = 1'b0;

        $display("[TB] reset during write access");
        @(negedge clk); #1;
        setPort(1'b0, 1, 1, 8'h10, 16'h00AB);
        @(negedge clk);
        checkOutput("write access we", mem_we, 1);
        #1 rst = 1'b1; a_req = 1'b0;
        @(negedge clk);
        checkOutput("rst write a_ack", a_ack, 0);
        checkOutput("rst write busy", busy, 0);
        checkOutput("rst write mem_we", mem_we, 0);
        #1 rst = 1'b0;
        setPort(1'b0, 1, 0, 8'h10, 16'h0);
        waitAck(1'b0, 10, lat, weCnt, rd);
        checkOutput("post-rst latency", lat, 2);
        checkOutput("committed write", rd, 16'h00AB);
        a_req = 1'b0;

        $display("[TB] reset during read access and response");
        @(negedge clk); #1;
        setPort(1'b0, 1, 0, 8'h02, 16'h0);
        @(negedge clk);
        checkOutput("read access busy", busy, 1);
        #1 rst = 1'b1; a_req = 1'b0;
        @(negedge clk);
        checkOutput("rst read a_ack", a_ack, 0);
        checkOutput("rst read rdata", rdata, 16'h0000);
        checkOutput("rst read busy", busy, 0);
        #1 rst = 1'b0;
        setPort(1'b0, 1, 0, 8'h10, 16'h0);
        waitAck(1'b0, 10, lat, weCnt, rd);
        checkOutput("resp read data", rd, 16'h00AB);
        rst = 1'b1; a_req = 1'b0;
        @(negedge clk);
        checkOutput("rst resp a_ack", a_ack, 0);
        checkOutput("rst resp rdata", rdata, 16'h0000);
        checkOutput("rst resp mem_addr", mem_addr, 8'h00);
        #1 rst = 1'b0;

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); #1;
            applyStimulus();
        end
        @(negedge clk); #1;
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem256x16_arbiter.md
Name: mem256x16_arbiter

Overview:
- Two-port access arbiter and sequencer for the Mem256X16 single-port 256x16 RAM.
- Memory write: synchronous, on clk when WEn=1. Memory read: qout is combinational from the address.
- Accepts independent read/write requests from ports A and B and serialises them onto the single RAM port.
- Returns read data and a one-cycle ack to the winning port; sits between the two bus masters and the RAM.

Parameters:
- ADDR_W, 8, RAM address width; mem_addr[i] drives addr<i>.
- DATA_W, 16, RAM data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read; stable while a_req.
- a_addr  in  ADDR_W  port A address; stable while a_req.
- a_wdata  in  DATA_W  port A write data; stable while a_req.
- a_ack  out  1  one-cycle completion pulse to port A.
- b_req, b_we, b_addr, b_wdata, b_ack: same as the A signals, for port B.
- rdata  out  DATA_W  read result; valid in the a_ack/b_ack cycle of a read.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  ADDR_W  to RAM addr0..addr7.
- mem_data  out  DATA_W  to RAM data.
- mem_we  out  1  to RAM WEn.
- mem_qout  in  DATA_W  from RAM qout.

Behaviour:
- Reset values (all outputs registered): state=IDLE, mem_addr=0, mem_data=0, mem_we=0, a_ack=0, b_ack=0, rdata=0, busy=0, last-winner pointer=A (so B wins the first contention under RR).
- FSM: IDLE -> ACCESS -> RESP -> IDLE. One access per 3 cycles.
- IDLE:
  - If any req is high, select the winner and latch its addr/wdata/we into mem_addr/mem_data/mem_we and winner_id; go to ACCESS.
  - With no req, stay in IDLE; mem_we stays 0.
- ACCESS:
  - Write: mem_we=1 for exactly this cycle; the RAM writes on the closing edge.
  - Read: mem_qout is captured into rdata on the closing edge.
  - Then clear mem_we and go to RESP.
- RESP:
  - Pulse ack[winner_id]=1 for one cycle.
  - rdata holds its value until the next read capture; writes do not change rdata.
  - Go to IDLE.
- Latency: req seen in IDLE in cycle 0 gives ack in cycle 2.
- Requester rule: deassert req in the cycle after ack, or keep it high to issue a new request. A still-high req in that IDLE cycle is treated as a new request.
- A req rising while the FSM is busy waits; it is never dropped.
- Arbitration: decided only in IDLE. A request is never pre-empted once latched.
- Simultaneous A and B in IDLE: resolved per the optional feature. The loser is served in the next IDLE, i.e. its ack arrives 3 cycles after the winner's.
- Same address from both ports: strictly ordered by the grant, so a read issued after a write returns the new data.
- Reset mid-operation:
  - At the next edge: IDLE, mem_we=0, no ack issued.
  - A write whose ACCESS cycle coincides with the rst edge still commits to the RAM, because WEn is already high. The requester must reissue the request.
- Address range: full 0x00..0xFF with no wrap or translation. Out-of-range addresses are impossible by width.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin. On contention, the port that did not win last gets the grant. The pointer updates on every grant, contended or not.
- Undefined: fixed priority, A always beats B. The pointer logic is removed.

Decomposition:
- Shared package mem_arb_pkg:
  - ADDR_W/DATA_W constants.
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Requester id constants (ID_A=1'b0, ID_B=1'b1).
- One natural sub-module, arb2_pick: combinational two-way picker.
  - Inputs: req_a, req_b, last_id.
  - Outputs: win_id and any_req.
  - Contains the MEM_ARB_RR_EN selection; the FSM stays in the top.

Test Plan:
- Reset, then A writes 0x0001 to 0x01 (a_req held): mem_we high exactly 1 cycle, a_ack in cycle 2; A then reads 0x01 -> rdata=0x0001 with a_ack.
- A writes 0x0006 to 0x84 while B writes 0x0012 to 0x48 in the same cycle: both acks, 3 cycles apart. Order is A then B with the macro undefined; with MEM_ARB_RR_EN, B first after reset. Readback of 0x84/0x48 = 0x0006/0x0012.
- RR build, both requesters held continuously for 6 accesses: acks strictly alternate A,B,A,B,A,B; non-RR build: A only until a_req drops.
- B writes 0x0010 to 0x02 then reads 0x02 back-to-back (req held through ack): second access starts in the IDLE cycle after ack; rdata=0x0010.
- rst asserted during RESP of a read: no ack that cycle; outputs back to reset values next cycle; busy=0.
- Idle with no req for 10 cycles: mem_we stays 0, busy=0, rdata unchanged.
